// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - shared types and constants for the register-bank arbiter
package spi_regbank_pkg;

    localparam int ADDR_W_DEF   = 3;
    localparam int DATA_W_DEF   = 8;
    localparam int NUM_REGS_DEF = 6;

    localparam int REQ_SPI  = 0;
    localparam int REQ_HOST = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
    import spi_regbank_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       valid,
    output logic       gnt
);

    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        // On a tie the requester that did not win last time goes next.
        if (req[REQ_SPI] && req[REQ_HOST]) begin
            gnt = ~last_gnt;
        end else if (req[REQ_HOST]) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/spi_regbank_arbiter.sv
// rtl/spi_regbank_arbiter.sv - shares the register-bank port between SPI decoder and host
module spi_regbank_arbiter
    import spi_regbank_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] rdata,
    output logic              bank_en,
    output logic              bank_we,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata
);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    state_t            state, state_d;
    logic              gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        ack_d, err_d;
    logic [DATA_W-1:0] rdata_d;
    logic              bank_en_d, bank_we_d;
    logic [ADDR_W-1:0] bank_addr_d;
    logic [DATA_W-1:0] bank_wdata_d;

    logic              pick_valid, pick_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .valid    (pick_valid),
        .gnt      (pick_gnt)
    );

    assign sel_we    = we[pick_gnt];
    assign sel_addr  = pick_gnt ? addr1  : addr0;
    assign sel_wdata = pick_gnt ? wdata1 : wdata0;

    always_comb begin
        state_d      = state;
        gnt_d        = gnt_q;
        last_gnt_d   = last_gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ack_d        = 2'b00;
        err_d        = 2'b00;
        rdata_d      = rdata;
        bank_en_d    = 1'b0;
        bank_we_d    = 1'b0;
        bank_addr_d  = bank_addr;
        bank_wdata_d = bank_wdata;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d      = pick_gnt;
                    last_gnt_d = pick_gnt;
                    we_d       = sel_we;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    state_d    = ACCESS;
                    // Bank strobe registers here so it is high for exactly the ACCESS cycle.
                    if (in_range(sel_addr)) begin
                        bank_en_d    = 1'b1;
                        bank_we_d    = sel_we;
                        bank_addr_d  = sel_addr;
                        bank_wdata_d = sel_wdata;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                ack_d[gnt_q] = 1'b1;
                err_d[gnt_q] = ~in_range(addr_q);
                rdata_d      = (!we_q && in_range(addr_q)) ? bank_rdata : '0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ack        <= 2'b00;
            err        <= 2'b00;
            rdata      <= '0;
            bank_en    <= 1'b0;
            bank_we    <= 1'b0;
            bank_addr  <= '0;
            bank_wdata <= '0;
        end else begin
            state      <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ack        <= ack_d;
            err        <= err_d;
            rdata      <= rdata_d;
            bank_en    <= bank_en_d;
            bank_we    <= bank_we_d;
            bank_addr  <= bank_addr_d;
            bank_wdata <= bank_wdata_d;
        end
    end

endmodule

// File: tb/tb_spi_regbank_arbiter.sv
// tb/tb_spi_regbank_arbiter.sv - directed self-checking bench for spi_regbank_arbiter
module tb_spi_regbank_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, we;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] ack, err;
    logic [7:0] rdata;
    logic       bank_en, bank_we;
    logic [2:0] bank_addr;
    logic [7:0] bank_wdata;
    logic [7:0] bank_rdata;

    logic [7:0] mem [0:7];
    logic       mem_init;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    spi_regbank_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ack        (ack),
        .err        (err),
        .rdata      (rdata),
        .bank_en    (bank_en),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata)
    );

    // Synchronous bank: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'(8'h40 + i);
            bank_rdata <= 8'h00;
        end else if (bank_en) begin
            if (bank_we) mem[bank_addr] <= bank_wdata;
            bank_rdata <= mem[bank_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset
        repeat (3) tick();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_bank_en", 32'(bank_en), 32'h0);
        check("rst_bank_we", 32'(bank_we), 32'h0);
        check("rst_bank_addr", 32'(bank_addr), 32'h0);
        check("rst_bank_wdata", 32'(bank_wdata), 32'h0);
        rst = 1'b0; mem_init = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_quiet", 32'({bank_en, ack}), 32'h0);
        end

        // Single write from requester 0
        req = 2'b01; we = 2'b01; addr0 = 3'd2; wdata0 = 8'hA5;
        tick();
        req = 2'b00;
        check("wr_bank_en", 32'(bank_en), 32'h1);
        check("wr_bank_we", 32'(bank_we), 32'h1);
        check("wr_bank_addr", 32'(bank_addr), 32'h2);
        check("wr_bank_wdata", 32'(bank_wdata), 32'hA5);
        check("wr_ack_early", 32'(ack), 32'h0);
        tick();
        check("wr_bank_en_drop", 32'(bank_en), 32'h0);
        check("wr_ack_mid", 32'(ack), 32'h0);
        tick();
        check("wr_ack", 32'(ack), 32'h1);
        check("wr_err", 32'(err), 32'h0);
        check("wr_rdata", 32'(rdata), 32'h0);
        tick();
        check("wr_ack_gone", 32'(ack), 32'h0);

        // Read-back from requester 1
        req = 2'b10; we = 2'b00; addr1 = 3'd2;
        tick();
        req = 2'b00;
        check("rd_bank_en", 32'(bank_en), 32'h1);
        check("rd_bank_we", 32'(bank_we), 32'h0);
        check("rd_bank_addr", 32'(bank_addr), 32'h2);
        tick();
        tick();
        check("rd_ack", 32'(ack), 32'h2);
        check("rd_rdata", 32'(rdata), 32'hA5);
        check("rd_err", 32'(err), 32'h0);
        tick();
        check("rd_ack_gone", 32'(ack), 32'h0);
        check("rd_rdata_hold", 32'(rdata), 32'hA5);

        // Contention: requester 0 writes addr 1, requester 1 reads addr 3
        we = 2'b01; addr0 = 3'd1; wdata0 = 8'h11; addr1 = 3'd3;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("cont_bank_en", 32'(bank_en), 32'h1);
            check("cont_bank_addr", 32'(bank_addr), (k % 2 == 0) ? 32'h1 : 32'h3);
            check("cont_ack_a", 32'(ack), 32'h0);
            tick();
            check("cont_ack_b", 32'(ack), 32'h0);
            tick();
            check("cont_ack", 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h2);
            check("cont_rdata", 32'(rdata), (k % 2 == 0) ? 32'h0 : 32'h43);
            if (k == 3) req = 2'b00;
        end
        check("cont_mem1", 32'(mem[1]), 32'h11);

        // Out-of-range read by requester 1
        req = 2'b10; we = 2'b00; addr1 = 3'd6;
        tick();
        req = 2'b00;
        check("oor_rd_bank_en", 32'(bank_en), 32'h0);
        tick();
        check("oor_rd_bank_en2", 32'(bank_en), 32'h0);
        tick();
        check("oor_rd_ack", 32'(ack), 32'h2);
        check("oor_rd_err", 32'(err), 32'h2);
        check("oor_rd_rdata", 32'(rdata), 32'h0);

        // Highest in-range address
        req = 2'b10; we = 2'b00; addr1 = 3'd5;
        tick();
        req = 2'b00;
        check("edge_bank_en", 32'(bank_en), 32'h1);
        tick();
        tick();
        check("edge_ack", 32'(ack), 32'h2);
        check("edge_err", 32'(err), 32'h0);
        check("edge_rdata", 32'(rdata), 32'h45);

        // Out-of-range write by requester 0
        req = 2'b01; we = 2'b01; addr0 = 3'd7; wdata0 = 8'h3C;
        tick();
        req = 2'b00;
        check("oor_wr_bank_en", 32'(bank_en), 32'h0);
        tick();
        check("oor_wr_bank_en2", 32'(bank_en), 32'h0);
        tick();
        check("oor_wr_ack", 32'(ack), 32'h1);
        check("oor_wr_err", 32'(err), 32'h1);
        check("oor_wr_rdata", 32'(rdata), 32'h0);
        tick();
        check("oor_wr_err_gone", 32'(err), 32'h0);

        // Reset in the ACCESS cycle, request kept pending
        req = 2'b01; we = 2'b01; addr0 = 3'd4; wdata0 = 8'h77;
        tick();
        check("mid_bank_en", 32'(bank_en), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_bank_en", 32'(bank_en), 32'h0);
        check("mid_rst_bank_addr", 32'(bank_addr), 32'h0);
        check("mid_rst_ack", 32'(ack), 32'h0);
        tick();
        check("mid_rst_no_write", 32'(mem[4]), 32'h44);
        check("mid_rst_ack2", 32'(ack), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        req = 2'b00;
        check("resv_bank_en", 32'(bank_en), 32'h1);
        check("resv_bank_addr", 32'(bank_addr), 32'h4);
        check("resv_bank_wdata", 32'(bank_wdata), 32'h77);
        tick();
        tick();
        check("resv_ack", 32'(ack), 32'h1);
        check("resv_err", 32'(err), 32'h0);
        tick();
        check("resv_mem4", 32'(mem[4]), 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
